// File: rtl/ram8_fifo_ctrl_if.sv
// ram8_fifo_ctrl_if: producer/consumer handshakes, occupancy and RAM8 port of the FIFO controller
//   wr_valid/wr_ready/wr_data : push side
//   rd_valid/rd_ready/rd_data : pop side (rd_data registered)
//   count                     : entries held, 0..9
//   ram_in/ram_load/ram_address/ram_out : RAM8 storage port (ram_out is a combinational read)
interface ram8_fifo_ctrl_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic [3:0] count;
    logic [7:0] ram_in;
    logic       ram_load;
    logic [2:0] ram_address;
    logic [7:0] ram_out;

    modport master (
        output wr_valid, wr_data, rd_ready, ram_out,
        input  wr_ready, rd_valid, rd_data, count, ram_in, ram_load, ram_address
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready, ram_out,
        output wr_ready, rd_valid, rd_data, count, ram_in, ram_load, ram_address
    );
endinterface

// File: rtl/ram8_fifo_ctrl.sv
// ram8_fifo_ctrl: 8-bit FIFO controller over a single-port 8-entry RAM8 plus a registered output stage
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   flush_i : synchronous clear of all queued data
//   bus     : slave modport carrying push/pop handshakes, count and the RAM8 port
module ram8_fifo_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    ram8_fifo_ctrl_if.slave   bus
);
    logic [2:0] wr_ptr_q, wr_ptr_d;
    logic [2:0] rd_ptr_q, rd_ptr_d;
    logic [3:0] ram_count_q, ram_count_d;
    logic       rd_valid_q, rd_valid_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       fetch;
    logic       push;

    // The single RAM port serves a fetch into the output stage before any push.
    assign fetch = !flush_i && ram_count_q != 4'd0 && (!rd_valid_q || bus.rd_ready);
    // rst_n gating keeps RAM8 untouched while reset is held.
    assign bus.wr_ready = rst_n && !flush_i && !fetch && ram_count_q != 4'd8;
    assign push = bus.wr_valid && bus.wr_ready;

    assign bus.ram_address = fetch ? rd_ptr_q : wr_ptr_q;
    assign bus.ram_in      = bus.wr_data;
    assign bus.ram_load    = push;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.count       = ram_count_q + {3'b000, rd_valid_q};

    always_comb begin
        wr_ptr_d    = flush_i ? 3'd0 : wr_ptr_q + {2'b00, push};
        rd_ptr_d    = flush_i ? 3'd0 : rd_ptr_q + {2'b00, fetch};
        ram_count_d = flush_i ? 4'd0 : ram_count_q + {3'b000, push} - {3'b000, fetch};
        rd_valid_d  = flush_i ? 1'b0 : fetch ? 1'b1 : (rd_valid_q && bus.rd_ready) ? 1'b0 : rd_valid_q;
        rd_data_d   = fetch ? bus.ram_out : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= 3'd0;
            rd_ptr_q    <= 3'd0;
            ram_count_q <= 4'd0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= 8'h00;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_count_q <= ram_count_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end
endmodule

// File: tb/tb_ram8_fifo_ctrl.sv
// tb_ram8_fifo_ctrl: directed self-checking bench for ram8_fifo_ctrl with a behavioural RAM8
module tb_ram8_fifo_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] mem [8];

    ram8_fifo_ctrl_if bus ();

    ram8_fifo_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.ram_load) mem[bus.ram_address] <= bus.ram_in;
    assign bus.ram_out = mem[bus.ram_address];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] w);
        int n = 0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = w;
        #1;
        while (!bus.wr_ready && n < 10) begin
            step();
            #1;
            n++;
        end
        check("push_ready", {7'd0, bus.wr_ready}, 8'd1);
        step();
        bus.wr_valid = 1'b0;
    endtask

    initial begin
        int sent;
        int got;
        logic prev_load;
        for (int i = 0; i < 8; i++) mem[i] = 8'hEE;
        rst_n = 1'b1;
        flush = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        bus.rd_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_count", {4'd0, bus.count}, 8'd0);
        check("rst_rd_valid", {7'd0, bus.rd_valid}, 8'd0);
        check("rst_rd_data", bus.rd_data, 8'h00);
        check("rst_ram_load", {7'd0, bus.ram_load}, 8'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("rel_wr_ready", {7'd0, bus.wr_ready}, 8'd1);

        // single word: write edge then fetch edge
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hA5;
        #1;
        check("a5_load", {7'd0, bus.ram_load}, 8'd1);
        check("a5_addr", {5'd0, bus.ram_address}, 8'd0);
        step();
        bus.wr_valid = 1'b0;
        #1;
        check("a5_not_yet", {7'd0, bus.rd_valid}, 8'd0);
        step();
        #1;
        check("a5_data", bus.rd_data, 8'hA5);
        check("a5_valid", {7'd0, bus.rd_valid}, 8'd1);
        check("a5_count", {4'd0, bus.count}, 8'd1);
        step();
        check("a5_hold", bus.rd_data, 8'hA5);
        flush = 1'b1;
        step();
        flush = 1'b0;

        // fill to 9 with consumer stalled
        for (int w = 1; w <= 9; w++) push(8'(w));
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h0A;
        #1;
        check("full_count", {4'd0, bus.count}, 8'd9);
        check("full_wr_ready", {7'd0, bus.wr_ready}, 8'd0);
        check("full_ram_load", {7'd0, bus.ram_load}, 8'd0);
        step();
        #1;
        check("full_count2", {4'd0, bus.count}, 8'd9);
        bus.wr_valid = 1'b0;

        // drain full queue
        bus.rd_ready = 1'b1;
        #1;
        for (int w = 1; w <= 9; w++) begin
            check("drain_valid", {7'd0, bus.rd_valid}, 8'd1);
            check("drain_data", bus.rd_data, 8'(w));
            step();
            #1;
        end
        check("drain_empty_valid", {7'd0, bus.rd_valid}, 8'd0);
        check("drain_empty_count", {4'd0, bus.count}, 8'd0);

        // stream 20 words with consumer always ready
        sent = 0;
        got = 0;
        prev_load = 1'b0;
        for (int c = 0; c < 100 && got < 20; c++) begin
            bus.wr_valid = sent < 20;
            bus.wr_data  = 8'(sent);
            #1;
            if (bus.rd_valid) begin
                check("stream_data", bus.rd_data, 8'(got));
                got++;
            end
            if (bus.ram_load) begin
                check("stream_alternate", {7'd0, prev_load}, 8'd0);
                sent++;
            end
            prev_load = bus.ram_load;
            step();
        end
        bus.wr_valid = 1'b0;
        #1;
        check("stream_got", 8'(got), 8'd20);
        check("stream_count", {4'd0, bus.count}, 8'd0);

        // flush with queue at 5
        bus.rd_ready = 1'b0;
        for (int w = 0; w < 5; w++) push(8'h10 + 8'(w));
        #1;
        check("pre_flush_count", {4'd0, bus.count}, 8'd5);
        flush = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h77;
        bus.rd_ready = 1'b1;
        #1;
        check("flush_load", {7'd0, bus.ram_load}, 8'd0);
        check("flush_wr_ready", {7'd0, bus.wr_ready}, 8'd0);
        step();
        flush = 1'b0;
        bus.wr_valid = 1'b0;
        #1;
        check("post_flush_count", {4'd0, bus.count}, 8'd0);
        check("post_flush_valid", {7'd0, bus.rd_valid}, 8'd0);
        check("post_flush_wr_ready", {7'd0, bus.wr_ready}, 8'd1);

        // asynchronous reset mid-stream
        bus.rd_ready = 1'b0;
        for (int w = 0; w < 4; w++) push(8'h20 + 8'(w));
        #1;
        check("pre_rst_count", {4'd0, bus.count}, 8'd4);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h99;
        #1 rst_n = 1'b0;
        #1;
        check("async_valid", {7'd0, bus.rd_valid}, 8'd0);
        check("async_count", {4'd0, bus.count}, 8'd0);
        check("async_no_load", {7'd0, bus.ram_load}, 8'd0);
        step();
        rst_n = 1'b1;
        bus.wr_data = 8'h3C;
        #1;
        check("rel_3c_addr", {5'd0, bus.ram_address}, 8'd0);
        check("rel_3c_load", {7'd0, bus.ram_load}, 8'd1);
        step();
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b1;
        step();
        bus.rd_ready = 1'b0;
        #1;
        check("rel_3c_data", bus.rd_data, 8'h3C);
        check("rel_3c_valid", {7'd0, bus.rd_valid}, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
